alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of command queue entries; legal values are 2, 4 and 8.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  queue can accept a command this cycle.
REQ-006 Port: cmd_a  input  4  operand a.
REQ-007 Port: cmd_b  input  4  operand b.
REQ-008 Port: cmd_sel  input  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 Port: alu_a  output  4  operand a driven to the downstream combinational alu.
REQ-010 Port: alu_b  output  4  operand b driven to the alu.
REQ-011 Port: alu_sel  output  2  opcode driven to the alu.
REQ-012 Port: alu_result  input  4  combinational result returned by the alu.
REQ-013 Port: res_valid  output  1  res_data holds an unconsumed result.
REQ-014 Port: res_ready  input  1  downstream consumer accepts the result.
REQ-015 Port: res_data  output  4  registered ALU result.
REQ-016 Port: res_sel  output  2  opcode that produced res_data.
REQ-017 Port: cmd_count  output  4  current queue occupancy, 0..DEPTH.

Function
REQ-018 Command transfer SHALL occur on a rising edge where cmd_valid and cmd_ready are both 1; the command SHALL be written at the tail.
REQ-019 cmd_ready SHALL equal (cmd_count < DEPTH), registered-state based, and SHALL NOT depend on res_ready in the same cycle.
REQ-020 Queue SHALL be FIFO order; tail and head pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 alu_a, alu_b and alu_sel SHALL combinationally present the head entry when cmd_count > 0, and SHALL be 0 when the queue is empty.
REQ-022 Issue SHALL occur on an edge where cmd_count > 0 and (res_valid == 0 or res_ready == 1).
REQ-023 On issue: res_data <= alu_result, res_sel <= head opcode, res_valid <= 1, and the head entry is popped.
REQ-024 On an edge with res_valid && res_ready and no issue, res_valid SHALL go to 0; res_data and res_sel SHALL hold.
REQ-025 While res_valid && !res_ready, res_data, res_sel and the queue head SHALL hold unchanged.
REQ-026 Latency: a command accepted at edge N into an empty queue, with the result stage free, SHALL appear with res_valid=1 after edge N+1.
REQ-027 Sustained throughput with res_ready=1 SHALL be one result per cycle.
REQ-028 Simultaneous push and issue on the same edge SHALL leave cmd_count unchanged and corrupt no entry, including when count is 1.
REQ-029 When full, cmd_valid SHALL be ignored; no entry SHALL be overwritten.
REQ-030 cmd_count SHALL update as +1 on push only, -1 on issue only, and unchanged on both or neither.

Reset
REQ-031 On rst=1, immediately and independent of clk, the block SHALL clear pointers, cmd_count=0, res_valid=0, res_data=0 and res_sel=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued commands and any pending result; no result SHALL appear after reset release without a new command.
REQ-033 After rst deasserts, cmd_ready SHALL be 1 on the first cycle.

Verification
REQ-034 Push a=0101, b=0011 with sel 00, 01, 10, 11 back-to-back, res_ready=1 -> res_data 1000, 0010, 0001, 0111 in order, on consecutive cycles, with matching res_sel.
REQ-035 Hold res_ready=0 and push DEPTH+1 commands -> one in result stage plus DEPTH queued, cmd_count=DEPTH, cmd_ready=0, and the extra command is not accepted; releasing res_ready drains all results in order.
REQ-036 Push a=1111, b=0001 with sel 00 -> res_data 0000 (4-bit wrap); a=0000, b=0001 with sel 01 -> res_data 1111.
REQ-037 With cmd_count=1 and res_ready=1, push and issue on the same edge -> cmd_count stays 1, and the next result is the newly pushed command.
REQ-038 Assert rst asynchronously between edges with 3 commands queued and res_valid=1 -> outputs reach the reset values before the next edge, and cmd_count=0.
REQ-039 With the queue empty -> alu_a=0, alu_b=0, alu_sel=00, and res_valid falls after the last result is consumed.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Command FIFO feeding an external combinational ALU, with a one-entry
// registered result stage using valid/ready handshakes on both sides.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_sel,
  output logic [3:0] cmd_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [3:0] FULL = 4'(DEPTH);

  logic [3:0]    qa [DEPTH];
  logic [3:0]    qb [DEPTH];
  logic [1:0]    qs [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          empty;
  logic          push;
  logic          issue;

  assign empty     = (cmd_count == '0);
  assign cmd_ready = (cmd_count < FULL);
  assign push      = cmd_valid && cmd_ready;
  // The result stage frees up in the same cycle it is consumed.
  assign issue     = !empty && (!res_valid || res_ready);

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = qa[head];
      alu_b   = qb[head];
      alu_sel = qs[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qa[tail] <= cmd_a;
      qb[tail] <= cmd_b;
      qs[tail] <= cmd_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      cmd_count <= '0;
    end else begin
      if (push) begin
        tail <= (tail == LAST) ? '0 : tail + PW'(1);
      end
      if (issue) begin
        head <= (head == LAST) ? '0 : head + PW'(1);
      end
      if (push && !issue) begin
        cmd_count <= cmd_count + 4'd1;
      end else if (issue && !push) begin
        cmd_count <= cmd_count - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sel   <= '0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_sel   <= alu_sel;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against a queue-based
// reference model of command order and result-stage handshaking.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_sel;
  logic [3:0] cmd_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
  } cmd_t;

  cmd_t       mq[$];
  bit         m_rv;
  logic [3:0] m_rd;
  logic [1:0] m_rs;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sel   (res_sel),
    .cmd_count (cmd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] s);
    int r;
    case (s)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 4'(r % 16);
  endfunction

  // Downstream combinational ALU.
  always_comb alu_result = alu_fn(alu_a, alu_b, alu_sel);

  task automatic model_reset();
    mq.delete();
    m_rv = 1'b0;
    m_rd = '0;
    m_rs = '0;
  endtask

  // Drive inputs, advance one edge, update the model, settle 1ns past the edge.
  task automatic tick(input bit v, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s, input bit rr);
    int   cnt;
    bit   do_push;
    bit   do_issue;
    cmd_t c;
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    res_ready = rr;
    cnt      = mq.size();
    do_push  = v && (cnt < DEPTH);
    do_issue = (cnt > 0) && (!m_rv || rr);
    @(posedge clk);
    if (do_issue) begin
      c    = mq.pop_front();
      m_rd = alu_fn(c.a, c.b, c.s);
      m_rs = c.s;
      m_rv = 1'b1;
    end else if (m_rv && rr) begin
      m_rv = 1'b0;
    end
    if (do_push) mq.push_back('{a: a, b: b, s: s});
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 3) tick(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_count !== 4'd0 || res_valid !== 1'b0 || res_data !== 4'd0 || res_sel !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: count=%0d rv=%b rd=%h rs=%0d, required 0 0 0 0",
               cmd_count, res_valid, res_data, res_sel);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_ops();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'b1000; exp_d[1] = 4'b0010; exp_d[2] = 4'b0001; exp_d[3] = 4'b0111;
    tick(1'b1, 4'b0101, 4'b0011, 2'd0, 1'b1);
    n_cmp++;
    if (res_valid !== 1'b0 || cmd_count !== 4'd1) begin
      n_err++;
      $display("FAIL ops_latency: rv=%b count=%0d, required 0 1", res_valid, cmd_count);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(k < 4, 4'b0101, 4'b0011, 2'(k), 1'b1);
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== exp_d[k-1] || res_sel !== 2'(k-1)) begin
        n_err++;
        $display("FAIL ops_result%0d: rv=%b rd=%b rs=%0d, required 1 %b %0d",
                 k-1, res_valid, res_data, res_sel, exp_d[k-1], k-1);
      end
    end
    tick(1'b0, '0, '0, '0, 1'b1);
    n_cmp++;
    if (res_valid !== 1'b0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_sel !== 2'd0) begin
      n_err++;
      $display("FAIL ops_empty: rv=%b alu=%h/%h/%0d, required 0 0/0/0",
               res_valid, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1);
    tick(1'b1, 4'b0000, 4'b0001, 2'd1, 1'b1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 4'b0000 || res_sel !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_add: rv=%b rd=%b rs=%0d, required 1 0000 0", res_valid, res_data, res_sel);
    end
    tick(1'b0, '0, '0, '0, 1'b1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 4'b1111 || res_sel !== 2'd1) begin
      n_err++;
      $display("FAIL wrap_sub: rv=%b rd=%b rs=%0d, required 1 1111 1", res_valid, res_data, res_sel);
    end
    drain();
  endtask

  task automatic test_full();
    cmd_t sent [DEPTH+1];
    cmd_t c;
    for (int i = 0; i <= DEPTH; i++) begin
      sent[i] = cmd_t'($urandom);
      tick(1'b1, sent[i].a, sent[i].b, sent[i].s, 1'b0);
    end
    n_cmp++;
    if (cmd_count !== 4'(DEPTH) || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_state: count=%0d ready=%b rv=%b, required %0d 0 1",
               cmd_count, cmd_ready, res_valid, DEPTH);
    end
    c = cmd_t'($urandom);
    tick(1'b1, c.a, c.b, c.s, 1'b0);
    n_cmp++;
    if (cmd_count !== 4'(DEPTH) || res_data !== alu_fn(sent[0].a, sent[0].b, sent[0].s)) begin
      n_err++;
      $display("FAIL full_extra: count=%0d rd=%h, required %0d %h", cmd_count, res_data,
               DEPTH, alu_fn(sent[0].a, sent[0].b, sent[0].s));
    end
    for (int i = 0; i <= DEPTH; i++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== alu_fn(sent[i].a, sent[i].b, sent[i].s) ||
          res_sel !== sent[i].s) begin
        n_err++;
        $display("FAIL full_drain%0d: rv=%b rd=%h rs=%0d, required 1 %h %0d", i, res_valid,
                 res_data, res_sel, alu_fn(sent[i].a, sent[i].b, sent[i].s), sent[i].s);
      end
      tick(1'b0, '0, '0, '0, 1'b1);
    end
    n_cmp++;
    if (res_valid !== 1'b0 || cmd_count !== 4'd0 || alu_a !== 4'd0 || alu_sel !== 2'd0) begin
      n_err++;
      $display("FAIL full_after: rv=%b count=%0d alu_a=%h alu_sel=%0d, required 0 0 0 0",
               res_valid, cmd_count, alu_a, alu_sel);
    end
  endtask

  task automatic test_same_edge();
    cmd_t c0;
    cmd_t c1;
    c0 = cmd_t'($urandom);
    c1 = cmd_t'($urandom);
    tick(1'b1, c0.a, c0.b, c0.s, 1'b1);
    tick(1'b1, c1.a, c1.b, c1.s, 1'b1);
    n_cmp++;
    if (cmd_count !== 4'd1 || res_data !== alu_fn(c0.a, c0.b, c0.s) || res_sel !== c0.s) begin
      n_err++;
      $display("FAIL same_edge: count=%0d rd=%h rs=%0d, required 1 %h %0d", cmd_count,
               res_data, res_sel, alu_fn(c0.a, c0.b, c0.s), c0.s);
    end
    tick(1'b0, '0, '0, '0, 1'b1);
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== alu_fn(c1.a, c1.b, c1.s) || res_sel !== c1.s) begin
      n_err++;
      $display("FAIL same_edge_next: rv=%b rd=%h rs=%0d, required 1 %h %0d", res_valid,
               res_data, res_sel, alu_fn(c1.a, c1.b, c1.s), c1.s);
    end
    drain();
  endtask

  task automatic test_async_reset();
    cmd_t c;
    for (int i = 0; i < 4; i++) begin
      c = cmd_t'($urandom);
      tick(1'b1, c.a, c.b, c.s | 2'd1, 1'b0);
    end
    n_cmp++;
    if (cmd_count !== 4'd3 || res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_setup: count=%0d rv=%b, required 3 1", cmd_count, res_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_count !== 4'd0 || res_valid !== 1'b0 || res_data !== 4'd0 || res_sel !== 2'd0 ||
        alu_a !== 4'd0 || alu_b !== 4'd0) begin
      n_err++;
      $display("FAIL arst_midcycle: count=%0d rv=%b rd=%h rs=%0d alu=%h/%h, required all 0",
               cmd_count, res_valid, res_data, res_sel, alu_a, alu_b);
    end
    model_reset();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, '0, '0, 1'b1);
      n_cmp++;
      if (res_valid !== 1'b0 || cmd_count !== 4'd0 || cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL arst_after%0d: rv=%b count=%0d ready=%b, required 0 0 1",
                 i, res_valid, cmd_count, cmd_ready);
      end
    end
  endtask

  task automatic test_random();
    cmd_t c;
    cmd_t h;
    for (int i = 0; i < 400; i++) begin
      c = cmd_t'($urandom);
      tick($urandom_range(0, 3) != 0, c.a, c.b, c.s, $urandom_range(0, 9) < 6);
      h = (mq.size() > 0) ? mq[0] : '0;
      n_cmp++;
      if (cmd_count !== 4'(mq.size()) || cmd_ready !== (mq.size() < DEPTH) ||
          res_valid !== m_rv || res_data !== m_rd || res_sel !== m_rs ||
          alu_a !== h.a || alu_b !== h.b || alu_sel !== h.s) begin
        n_err++;
        $display("FAIL random%0d: count=%0d ready=%b rv=%b rd=%h rs=%0d alu=%h/%h/%0d, required %0d %b %b %h %0d %h/%h/%0d",
                 i, cmd_count, cmd_ready, res_valid, res_data, res_sel, alu_a, alu_b, alu_sel,
                 mq.size(), mq.size() < DEPTH, m_rv, m_rd, m_rs, h.a, h.b, h.s);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ops();
    test_wrap();
    test_full();
    test_same_edge();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
